// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter and single-outstanding instruction fetch with IF/ID buffer
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] next_pc_i,
    input  logic        redirect_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, instr_q, instr_d;
    logic        valid_q, valid_d, capture, handoff;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            if_pc_q <= 32'h0;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
        end
    end
    // Redirect wins over everything; a pending grant must be drained before refetching.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ:   state_d = imem_gnt_i ? (redirect_i ? DRAIN : WAIT) : REQ;
            WAIT:  state_d = redirect_i ? (imem_rvalid_i ? REQ : DRAIN) : (imem_rvalid_i ? HOLD : WAIT);
            HOLD:  state_d = (redirect_i || if_ready_i) ? REQ : HOLD;
            DRAIN: state_d = imem_rvalid_i ? REQ : DRAIN;
        endcase
    end
    always_comb begin
        capture     = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
        handoff     = (state_q == HOLD) && if_ready_i && !redirect_i;
        pc_d        = (redirect_i || handoff) ? next_pc_i : pc_q;
        valid_d     = redirect_i ? 1'b0 : capture ? 1'b1 : handoff ? 1'b0 : valid_q;
        if_pc_d     = capture ? pc_q : if_pc_q;
        instr_d     = capture ? imem_rdata_i : instr_q;
        pc_o        = pc_q;
        imem_req_o  = (state_q == REQ);
        imem_addr_o = pc_q;
        if_valid_o  = valid_q;
        if_pc_o     = if_pc_q;
        if_instr_o  = instr_q;
    end
endmodule
